// File: rtl/soc_map_pkg.sv
// soc_map_pkg: shared address map for the data-bus slave.
// Holds the default MMIO base, the MMIO register byte offsets, the CON_STAT
// bit layout and a helper that packs the CON_STAT read word.
package soc_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hF000_0000;

  // Byte offsets within the 16-byte MMIO bank
  localparam logic [3:0] LED_OFS      = 4'h0;
  localparam logic [3:0] CYCLE_OFS    = 4'h4;
  localparam logic [3:0] CON_TX_OFS   = 4'h8;
  localparam logic [3:0] CON_STAT_OFS = 4'hC;

  // CON_STAT bit positions
  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  // Packs {16'b0, count[7:0], 5'b0, ovf, empty, full}
  function automatic logic [31:0] pack_con_stat(input logic [7:0] count,
                                                input logic       ovf,
                                                input logic       empty,
                                                input logic       full);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STAT_COUNT_LSB +: 8] = count;
    w[STAT_OVF_BIT]        = ovf;
    w[STAT_EMPTY_BIT]      = empty;
    w[STAT_FULL_BIT]       = full;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with binary pointers one bit wider than the
// address so full/empty fall out of the MSB comparison.
// Ports: clk, rst (async active-low), push/din, pop, dout (head entry, zero
// when empty), full, empty, count (entries held).
// A push while full is accepted only when a pop happens in the same cycle.
import soc_map_pkg::*;

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status flags, accepted push/pop, and head-entry view
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count   = wr_ptr - rd_ptr;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (empty) begin
      dout = '0;
    end else begin
      dout = mem[rd_ptr[AW-1:0]];
    end
  end

  // Pointer update; reset drops all held entries at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; when full with a pop, the write slot is the slot being freed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: slave end of the CPU data-memory interface.
// Ports: clk, rst (async active-low), addr/wdata/mem_w from the CPU MEM
// stage, rdata (combinational load data), led (LED register), and the
// console TX stream con_data/con_valid/con_ready.
// Targets: word RAM at 0, MMIO bank (LED, CYCLE, CON_TX, CON_STAT) at
// MMIO_BASE. Reads never change state; addr[1:0] is ignored.
import soc_map_pkg::*;

module data_bus_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_w,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  logic [31:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_hit;
  logic              mmio_hit;
  logic [3:0]        ofs;
  logic              ram_we;
  logic              led_we;
  logic              tx_push;
  logic              stat_we;
  logic              con_pop;
  logic [31:0]       cycle;
  logic              ovf;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_count;
  logic [31:0]       stat_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // Address decode and write strobes; RAM wins if the regions ever overlap
  always_comb begin
    ram_idx  = addr[RAM_AW+1:2];
    ram_hit  = (addr[31:RAM_AW+2] == '0);
    mmio_hit = !ram_hit && (addr[31:4] == MMIO_BASE[31:4]);
    ofs      = {addr[3:2], 2'b00};
    ram_we   = mem_w && ram_hit;
    led_we   = mem_w && mmio_hit && (ofs == LED_OFS);
    tx_push  = mem_w && mmio_hit && (ofs == CON_TX_OFS);
    stat_we  = mem_w && mmio_hit && (ofs == CON_STAT_OFS);
    con_pop  = con_valid && con_ready;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (wdata[7:0]),
    .pop   (con_ready),
    .dout  (con_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign con_valid = !fifo_empty;

  // Load-data mux; CON_TX reads alias CON_STAT
  always_comb begin
    stat_word = pack_con_stat(8'(fifo_count), ovf, fifo_empty, fifo_full);
    rdata     = 32'h0000_0000;
    if (ram_hit) begin
      rdata = ram[ram_idx];
    end else if (mmio_hit) begin
      case (ofs)
        LED_OFS:      rdata = {16'h0000, led};
        CYCLE_OFS:    rdata = cycle;
        CON_TX_OFS:   rdata = stat_word;
        CON_STAT_OFS: rdata = stat_word;
        default:      rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // RAM store port; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= wdata;
  end

  // MMIO registers; a dropped push beats a same-cycle ovf clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led   <= 16'h0000;
      cycle <= 32'h0000_0000;
      ovf   <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (led_we) led <= wdata[15:0];
      if (tx_push && fifo_full && !con_pop) begin
        ovf <= 1'b1;
      end else if (stat_we && wdata[STAT_OVF_BIT]) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed bus accesses with
// a byte scoreboard on the console TX stream.
module tb_data_bus_responder;

  localparam logic [31:0] MB        = 32'hF000_0000;
  localparam logic [31:0] A_LED     = MB + 32'h0;
  localparam logic [31:0] A_CYCLE   = MB + 32'h4;
  localparam logic [31:0] A_TX      = MB + 32'h8;
  localparam logic [31:0] A_STAT    = MB + 32'hC;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_w;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;

  int          n_checks;
  int          n_fail;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_byte;

  data_bus_responder #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (8),
    .MMIO_BASE  (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .mem_w     (mem_w),
    .rdata     (rdata),
    .led       (led),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    mem_w = 1'b1;
    @(posedge clk);
    #1;
    mem_w = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    bus_write(A_TX, {24'h0, b});
  endtask

  task automatic drain(input string tag);
    con_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid"}, {31'h0, con_valid}, 32'd0);
    con_ready = 1'b0;
  endtask

  // Scoreboard: a pop will happen at the next rising edge
  always @(negedge clk) begin
    if (rst && con_valid && con_ready) begin
      if (exp_q.size() == 0) begin
        check("con_extra_byte", {24'h0, con_data}, 32'hFFFF_FFFF);
      end else begin
        mon_byte = exp_q.pop_front();
        check("con_data", {24'h0, con_data}, {24'h0, mon_byte});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_w     = 1'b0;
    con_ready = 1'b0;
    #22;
    // Reset state
    check_rd("rst_led_rd", A_LED, 32'h0);
    check_rd("rst_cycle_rd", A_CYCLE, 32'h0);
    check_rd("rst_stat_rd", A_STAT, 32'h0000_0002);
    check("rst_con_valid", {31'h0, con_valid}, 32'h0);
    check("rst_con_data", {24'h0, con_data}, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);

    // CYCLE: 100 edges after release
    addr = A_CYCLE;
    @(negedge clk);
    rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check_rd("cycle_100", A_CYCLE, 32'd100);

    // CYCLE wrap
    force dut.cycle = 32'hFFFF_FFFF;
    #1;
    check("cycle_forced", rdata, 32'hFFFF_FFFF);
    release dut.cycle;
    @(posedge clk);
    #1;
    check_rd("cycle_wrap", A_CYCLE, 32'h0);
    bus_write(A_CYCLE, 32'h0000_AAAA);
    check_rd("cycle_ro", A_CYCLE, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check_rd("cycle_run", A_CYCLE, 32'd6);

    // RAM round trip
    bus_write(32'h0000_0014, 32'h1234_5678);
    bus_write(32'h0000_0000, 32'h1111_1111);
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    check_rd("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    check_rd("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
    check_rd("ram_14", 32'h0000_0014, 32'h1234_5678);
    // Read during a store to the same word returns the old value
    addr  = 32'h0000_0010;
    wdata = 32'hCAFE_F00D;
    mem_w = 1'b1;
    #1;
    check("ram_rd_old", rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    mem_w = 1'b0;
    check_rd("ram_rd_new", 32'h0000_0010, 32'hCAFE_F00D);
    bus_write(32'h0000_0FFC, 32'h0BAD_F00D);
    check_rd("ram_top", 32'h0000_0FFC, 32'h0BAD_F00D);
    // Just past RAM is unmapped and must not alias word 0
    bus_write(32'h0000_1000, 32'h9999_9999);
    check_rd("unmapped_rd", 32'h0000_1000, 32'h0);
    check_rd("ram_no_alias", 32'h0000_0000, 32'h1111_1111);
    bus_write(MB + 32'h10, 32'h7777_7777);
    check_rd("mmio_hole", MB + 32'h10, 32'h0);

    // LED
    bus_write(A_LED, 32'hFFFF_ABCD);
    check_rd("led_rd", A_LED, 32'h0000_ABCD);
    check("led_port", {16'h0, led}, 32'h0000_ABCD);

    // Console streaming
    push_byte(8'h41, 1'b1);
    check("stream_valid_lat1", {31'h0, con_valid}, 32'h1);
    push_byte(8'h42, 1'b1);
    push_byte(8'h43, 1'b1);
    @(posedge clk);
    #1;
    check("stream_hold", {24'h0, con_data}, 32'h41);
    check_rd("stream_stat", A_STAT, 32'h0000_0300);
    con_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stream_left", 32'(exp_q.size()), 32'd0);
    check("stream_valid_end", {31'h0, con_valid}, 32'h0);
    con_ready = 1'b0;

    // Overflow
    for (int i = 0; i < 9; i++) push_byte(8'h60 + 8'(i), i < 8);
    check_rd("ovf_stat", A_STAT, 32'h0000_0805);
    check_rd("ovf_tx_alias", A_TX, 32'h0000_0805);
    bus_write(A_STAT, 32'h0000_0004);
    check_rd("ovf_clear", A_STAT, 32'h0000_0801);
    drain("ovf_drain");
    check_rd("ovf_empty_stat", A_STAT, 32'h0000_0002);

    // Full with simultaneous pop
    for (int i = 0; i < 8; i++) push_byte(8'h70 + 8'(i), 1'b1);
    check_rd("fullpop_pre", A_STAT, 32'h0000_0801);
    con_ready = 1'b1;
    push_byte(8'h55, 1'b1);
    con_ready = 1'b0;
    check_rd("fullpop_stat", A_STAT, 32'h0000_0801);
    drain("fullpop_drain");

    // Side-effect-free reads
    for (int i = 0; i < 3; i++) push_byte(8'h31 + 8'(i), 1'b1);
    for (int i = 0; i < 6; i++) begin
      check_rd("sweep_rd", (i % 2 == 0) ? A_TX : A_STAT, 32'h0000_0300);
      @(posedge clk);
      #1;
    end
    check("sweep_head", {24'h0, con_data}, 32'h31);

    // Async reset mid-drain
    con_ready = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_valid", {31'h0, con_valid}, 32'h0);
    check("arst_led", {16'h0, led}, 32'h0);
    check("arst_data", {24'h0, con_data}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_rd("post_rst_stat", A_STAT, 32'h0000_0002);
    con_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
